// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the buffered UART transmitter:
//                FSM state encoding, clocks-per-bit rounding, CR/LF bytes.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam logic [7:0] C_CR = 8'h0D;
    localparam logic [7:0] C_LF = 8'h0A;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Byte write port of the buffered UART transmitter. The CPU
//                side (master) strobes bytes in and watches the status flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic       wr;
    logic [7:0] data;
    logic       full;
    logic       busy;
    logic       overflow;

    modport master (output wr, output data, input full, input busy, input overflow);
    modport slave  (input wr, input data, output full, output busy, output overflow);
endinterface

`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_fifo
//  Description : DEPTH x 8 register FIFO with first-word-fall-through read
//                data, registered full flag and an occupancy count.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
    input  wire logic               i_wr,
    input  wire logic [7:0]         i_wdata,
    input  wire logic               i_rd,
    output logic      [7:0]         o_rdata,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int                 c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_full_cnt = DEPTH[c_aw:0];
    localparam logic [c_aw:0]      c_cnt_one  = (c_aw + 1)'(1);
    localparam logic [c_aw-1:0]    c_ptr_one  = c_aw'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            r_full;

    logic            w_wr_acc;
    logic            w_rd_acc;
    logic [c_aw:0]   w_count_nxt;

    // A write is only taken when the registered full flag is low, so a write
    // while full is dropped even if a pop frees an entry in the same cycle.
    assign w_wr_acc = i_wr && !r_full;
    assign w_rd_acc = i_rd && (r_count != '0);

    // Next occupancy; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count and registered full flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_full_cnt);
        end
    end

    // Storage array; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered 8N1 UART transmitter. Bytes written through the
//                slave port are queued in uart_fifo and serialised LSB first
//                on txd. Frames from a non-empty queue run back to back.
//                Optional macro UART_TX_CRLF_EN expands each LF into CR LF.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 24000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    uart_tx_fifo_if.slave  bus,
    output logic           txd
);

    localparam int unsigned     DIV        = baud_div(CLK_HZ, BAUD);
    localparam int              c_bw       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_bw-1:0] c_div_last = c_bw'(DIV - 1);
    localparam logic [c_bw-1:0] c_baud_one = c_bw'(1);

    uart_state_t          r_state;
    uart_state_t          w_state_nxt;
    logic [c_bw-1:0]      r_baud;
    logic [c_bw-1:0]      w_baud_nxt;
    logic [2:0]           r_bit;
    logic [2:0]           w_bit_nxt;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_nxt;
    logic                 r_txd;
    logic                 w_txd_nxt;
    logic                 r_crlf;
    logic                 w_crlf_nxt;
    logic                 r_overflow;

    logic                 w_tick;
    logic                 w_pop;
    logic                 w_load;
    logic [7:0]           w_rdata;
    logic                 w_full;
    logic                 w_empty;
    logic [$clog2(DEPTH):0] w_count;

    uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_wr    (bus.wr),
        .i_wdata (bus.data),
        .i_rd    (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_tick = (r_baud == c_div_last);

    // Next-state, baud counter, shift register and line level for the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_crlf_nxt  = r_crlf;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_txd_nxt   = 1'b1;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_load      = 1'b1;
                    w_baud_nxt  = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = DATA;
                end else begin
                    w_baud_nxt  = r_baud + c_baud_one;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_nxt = STOP;
                    else               w_bit_nxt   = r_bit + 3'd1;
                end else begin
                    w_baud_nxt  = r_baud + c_baud_one;
                end
            end
            STOP: begin
                if (w_tick) begin
                    w_baud_nxt = '0;
                    if (r_crlf) begin
                        // Second half of an expanded LF: no pop, queue untouched.
                        w_shift_nxt = C_LF;
                        w_crlf_nxt  = 1'b0;
                        w_state_nxt = START;
                    end else if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_load      = 1'b1;
                        w_state_nxt = START;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_baud_one;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_load) begin
`ifdef UART_TX_CRLF_EN
            if (w_rdata == C_LF) begin
                w_shift_nxt = C_CR;
                w_crlf_nxt  = 1'b1;
            end else begin
                w_shift_nxt = w_rdata;
            end
`else
            w_shift_nxt = w_rdata;
`endif
        end

        // Line level follows the state being entered so txd is a clean flop output.
        case (w_state_nxt)
            START:   w_txd_nxt = 1'b0;
            DATA:    w_txd_nxt = w_shift_nxt[0];
            default: w_txd_nxt = 1'b1;
        endcase
    end

    // FSM state, datapath registers and registered serial output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_crlf  <= 1'b0;
            r_txd   <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_crlf  <= w_crlf_nxt;
            r_txd   <= w_txd_nxt;
        end
    end

    // Sticky overflow: any write attempted while the queue reports full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_overflow <= 1'b0;
        else if (bus.wr && w_full) r_overflow <= 1'b1;
    end

    assign txd          = r_txd;
    assign bus.full     = w_full;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state != IDLE) || (w_count != '0);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Self-checking bench for uart_tx_fifo. A line monitor decodes
//                every frame on txd and compares it against a queue of
//                expected bytes filled when writes are driven.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    // (24000000 + 57600) / 115200 rounds to 208 clocks per bit.
    localparam int DIV   = 208;
    localparam int FRAME = 10 * DIV;

    logic clk = 1'b0;
    logic reset_n;
    logic txd;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_HZ (24000000),
        .BAUD   (115200),
        .DEPTH  (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .txd     (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q [$];
    int         starts_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- line monitor / scoreboard ----------------
    bit         mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte;

    always @(negedge clk) begin
        if (reset_n !== 1'b1) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                starts_q.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % DIV) == DIV / 2) begin
                if (mon_cnt / DIV == 0) begin
                    chk("start_bit", txd, 1'b0);
                end else if (mon_cnt / DIV <= 8) begin
                    mon_byte[mon_cnt / DIV - 1] = txd;
                end else begin
                    chk("stop_bit", txd, 1'b1);
                    chk("frame_expected", (exp_q.size() > 0), 1'b1);
                    if (exp_q.size() > 0) chk("frame_byte", mon_byte, exp_q.pop_front());
                    mon_active = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_byte(input logic [7:0] d, input bit push);
        @(negedge clk);
        bus.wr   = 1'b1;
        bus.data = d;
        if (push) begin
`ifdef UART_TX_CRLF_EN
            if (d == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(d);
        end
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.busy !== 1'b0) chk(name, bus.busy, 1'b0);
    endtask

    typedef struct {
        int   k;
        logic txd;
        logic busy;
    } vec_t;

    vec_t vt [12];

    initial begin
        int rel;
        int ca;
        int n;

        // Observation points k clocks after the 0x55 write strobe.
        vt[0]  = '{0,    1'b1, 1'b1};
        vt[1]  = '{1,    1'b0, 1'b1};
        vt[2]  = '{208,  1'b0, 1'b1};
        vt[3]  = '{209,  1'b1, 1'b1};
        vt[4]  = '{416,  1'b1, 1'b1};
        vt[5]  = '{417,  1'b0, 1'b1};
        vt[6]  = '{1665, 1'b0, 1'b1};
        vt[7]  = '{1872, 1'b0, 1'b1};
        vt[8]  = '{1873, 1'b1, 1'b1};
        vt[9]  = '{2080, 1'b1, 1'b1};
        vt[10] = '{2081, 1'b1, 1'b0};
        vt[11] = '{2200, 1'b1, 1'b0};

        reset_n  = 1'b0;
        bus.wr   = 1'b0;
        bus.data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", txd, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single 0x55 frame, checked point by point.
        wr_byte(8'h55, 1'b1);
        rel = 0;
        for (int i = 0; i < 12; i++) begin
            while (rel < vt[i].k) begin
                @(posedge clk);
                rel++;
            end
            #1;
            chk($sformatf("t55_txd_k%0d", vt[i].k), txd, vt[i].txd);
            chk($sformatf("t55_busy_k%0d", vt[i].k), bus.busy, vt[i].busy);
        end

        // Three back-to-back frames.
        starts_q.delete();
        wr_byte(8'h41, 1'b1);
        wr_byte(8'h42, 1'b1);
        wr_byte(8'h43, 1'b1);
        wait_idle("b2b_timeout", 4 * FRAME);
        chk("b2b_frames", starts_q.size(), 3);
        if (starts_q.size() == 3) begin
            chk("b2b_gap1", starts_q[1] - starts_q[0], FRAME);
            chk("b2b_gap2", starts_q[2] - starts_q[1], FRAME);
        end

        // Fill to full, then one more write that must be dropped.
        for (int i = 1; i <= 17; i++) begin
            wr_byte(8'h60 + 8'(i), 1'b1);
            if (i == 16) chk("full_after_16", bus.full, 1'b0);
            if (i == 17) chk("full_after_17", bus.full, 1'b1);
        end
        chk("ovf_before_18", bus.overflow, 1'b0);
        wr_byte(8'hEE, 1'b0);
        chk("ovf_after_18", bus.overflow, 1'b1);
        chk("full_after_18", bus.full, 1'b1);
        wait_idle("drain_timeout", 19 * FRAME);
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("ovf_sticky", bus.overflow, 1'b1);

        // Reset in the middle of a frame.
        wr_byte(8'h5A, 1'b0);
        repeat (500) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_txd", txd, 1'b1);
        chk("midrst_full", bus.full, 1'b0);
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_overflow", bus.overflow, 1'b0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wr_byte(8'h00, 1'b1);
        wait_idle("postrst_timeout", 2 * FRAME);
        chk("postrst_queue_empty", exp_q.size(), 0);

        // Line feed: one frame verbatim, or CR + LF when expansion is built in.
        starts_q.delete();
        wr_byte(8'h0A, 1'b1);
        n = 0;
        while (bus.busy === 1'b1 && n < 3 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
        end
`ifdef UART_TX_CRLF_EN
        chk("lf_busy_clocks", n, 2 * FRAME + 1);
        chk("lf_frames", starts_q.size(), 2);
`else
        chk("lf_busy_clocks", n, FRAME + 1);
        chk("lf_frames", starts_q.size(), 1);
`endif

        // Write lands on the same edge as the pop that takes the queue's only byte.
        starts_q.delete();
        wr_byte(8'hA1, 1'b1);
        ca = cyc;
        repeat (10) @(posedge clk);
        #1;
        wr_byte(8'hB2, 1'b1);
        while (cyc < ca + FRAME) begin
            @(posedge clk);
            #1;
        end
        wr_byte(8'hC3, 1'b1);
        chk("simul_count", dut.u_fifo.r_count, 1);
        wait_idle("simul_timeout", 3 * FRAME);
        chk("simul_frames", starts_q.size(), 3);
        if (starts_q.size() == 3) begin
            chk("simul_first_start", starts_q[0], ca + 1);
            chk("simul_second_start", starts_q[1], ca + 1 + FRAME);
            chk("simul_third_gap", starts_q[2] - starts_q[1], FRAME);
        end
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
